// File: rtl/rf_wb_arb_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
// Optional perf counters are enabled with RF_WB_ARB_PERF_EN.
package rf_wb_arb_pkg;

   typedef enum logic [0:0] {
      NORMAL = 1'b0,
      FORCE  = 1'b1
   } arb_state_e;

   localparam int unsigned PERF_W = 32;

   function automatic int unsigned addr_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-destination scoreboard: one bit per register owed by the long-latency unit.
// A set and a clear of the same register in one cycle leave the bit set.
module rf_scoreboard
   import rf_wb_arb_pkg::*;
#(
   parameter  int unsigned REG_COUNT = 32,
   localparam int unsigned AW        = addr_width(REG_COUNT)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_set_valid,
   input  logic [AW-1:0]        i_set_rd,
   input  logic                 i_clr_valid,
   input  logic [AW-1:0]        i_clr_rd,
   output logic [REG_COUNT-1:0] o_pend_mask
);

   logic [REG_COUNT-1:0] r_pend;
   logic [REG_COUNT-1:0] w_pend_nxt;

   always_comb begin
      w_pend_nxt = r_pend;
      for (int unsigned r = 1; r < REG_COUNT; r++) begin
         if (i_clr_valid && (i_clr_rd == AW'(r))) w_pend_nxt[r] = 1'b0;
         if (i_set_valid && (i_set_rd == AW'(r))) w_pend_nxt[r] = 1'b1;
      end
      w_pend_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_pend <= '0;
      else     r_pend <= w_pend_nxt;
   end

   assign o_pend_mask = r_pend;

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: pipeline has priority, the long-latency unit
// is forced through after MAX_WAIT lost cycles. Macro RF_WB_ARB_PERF_EN adds perf counters.
module rf_wb_arbiter
   import rf_wb_arb_pkg::*;
#(
   parameter  int unsigned REG_WIDTH = 64,
   parameter  int unsigned REG_COUNT = 32,
   parameter  int unsigned MAX_WAIT  = 4,
   localparam int unsigned AW        = addr_width(REG_COUNT)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 pipe_wvalid,
   input  logic [AW-1:0]        pipe_waddr,
   input  logic [REG_WIDTH-1:0] pipe_wdata,
   output logic                 pipe_stall,
   input  logic                 lu_valid,
   output logic                 lu_ready,
   input  logic [AW-1:0]        lu_waddr,
   input  logic [REG_WIDTH-1:0] lu_wdata,
   input  logic                 lu_issue_valid,
   input  logic [AW-1:0]        lu_issue_rd,
   output logic [REG_COUNT-1:0] pend_mask,
   output logic                 rf_we,
   output logic [AW-1:0]        rf_waddr,
   output logic [REG_WIDTH-1:0] rf_wdata
`ifdef RF_WB_ARB_PERF_EN
   ,
   output logic [PERF_W-1:0]    perf_conflicts,
   output logic [PERF_W-1:0]    perf_forced
`endif
);

   localparam int unsigned      WCW     = $clog2(MAX_WAIT + 1);
   localparam logic [WCW-1:0]   CNT_MAX = WCW'(MAX_WAIT);

   arb_state_e           r_state;
   logic [WCW-1:0]       r_wait_cnt;
   logic [WCW-1:0]       w_cnt_inc;
   logic                 w_pipe_real;
   logic                 w_lu_real;
   logic                 w_force;
   logic                 w_lu_ready;
   logic                 w_pipe_stall;
   logic                 w_lu_wr;
   logic                 w_pipe_wr;
   logic                 r_rf_we;
   logic [AW-1:0]        r_rf_waddr;
   logic [REG_WIDTH-1:0] r_rf_wdata;

   always_comb begin
      w_pipe_real  = pipe_wvalid && (pipe_waddr != '0);
      w_lu_real    = lu_valid && (lu_waddr != '0);
      w_force      = (r_state == FORCE);
      w_lu_ready   = !rst && lu_valid && (w_force || !w_pipe_real);
      // FORCE with no LU result stalls nothing, so the pipeline write proceeds.
      w_pipe_stall = !rst && w_force && w_pipe_real && lu_valid;
      w_lu_wr      = w_lu_ready && w_lu_real;
      w_pipe_wr    = w_pipe_real && !w_pipe_stall && !w_lu_wr;
      w_cnt_inc    = r_wait_cnt + 1'b1;
   end

   assign lu_ready   = w_lu_ready;
   assign pipe_stall = w_pipe_stall;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= NORMAL;
         r_wait_cnt <= '0;
      end else begin
         if (lu_valid && !w_lu_ready) r_wait_cnt <= w_cnt_inc;
         else                         r_wait_cnt <= '0;
         if (w_force)
            r_state <= NORMAL;
         else if (lu_valid && !w_lu_ready && (w_cnt_inc == CNT_MAX))
            r_state <= FORCE;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rf_we    <= 1'b0;
         r_rf_waddr <= '0;
         r_rf_wdata <= '0;
      end else begin
         r_rf_we <= w_lu_wr || w_pipe_wr;
         if (w_lu_wr) begin
            r_rf_waddr <= lu_waddr;
            r_rf_wdata <= lu_wdata;
         end else if (w_pipe_wr) begin
            r_rf_waddr <= pipe_waddr;
            r_rf_wdata <= pipe_wdata;
         end
      end
   end

   assign rf_we    = r_rf_we;
   assign rf_waddr = r_rf_waddr;
   assign rf_wdata = r_rf_wdata;

   rf_scoreboard #(
      .REG_COUNT (REG_COUNT)
   ) u_scoreboard (
      .clk         (clk),
      .rst         (rst),
      .i_set_valid (lu_issue_valid),
      .i_set_rd    (lu_issue_rd),
      .i_clr_valid (w_lu_wr),
      .i_clr_rd    (lu_waddr),
      .o_pend_mask (pend_mask)
   );

`ifdef RF_WB_ARB_PERF_EN
   logic [PERF_W-1:0] r_perf_conflicts;
   logic [PERF_W-1:0] r_perf_forced;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_perf_conflicts <= '0;
         r_perf_forced    <= '0;
      end else begin
         if (!w_force && w_pipe_real && lu_valid && (r_perf_conflicts != '1))
            r_perf_conflicts <= r_perf_conflicts + 1'b1;
         if (w_pipe_stall && (r_perf_forced != '1))
            r_perf_forced <= r_perf_forced + 1'b1;
      end
   end

   assign perf_conflicts = r_perf_conflicts;
   assign perf_forced    = r_perf_forced;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_rf_wb_arbiter;

   localparam int unsigned RW = 64;
   localparam int unsigned RC = 32;
   localparam int unsigned MW = 4;
   localparam int unsigned AW = 5;

   logic          clk = 1'b0;
   logic          rst;
   logic          pipe_wvalid;
   logic [AW-1:0] pipe_waddr;
   logic [RW-1:0] pipe_wdata;
   logic          pipe_stall;
   logic          lu_valid;
   logic          lu_ready;
   logic [AW-1:0] lu_waddr;
   logic [RW-1:0] lu_wdata;
   logic          lu_issue_valid;
   logic [AW-1:0] lu_issue_rd;
   logic [RC-1:0] pend_mask;
   logic          rf_we;
   logic [AW-1:0] rf_waddr;
   logic [RW-1:0] rf_wdata;
`ifdef RF_WB_ARB_PERF_EN
   logic [31:0]   perf_conflicts;
   logic [31:0]   perf_forced;
`endif

   always #5 clk = ~clk;

   rf_wb_arbiter #(
      .REG_WIDTH (RW),
      .REG_COUNT (RC),
      .MAX_WAIT  (MW)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .pipe_wvalid    (pipe_wvalid),
      .pipe_waddr     (pipe_waddr),
      .pipe_wdata     (pipe_wdata),
      .pipe_stall     (pipe_stall),
      .lu_valid       (lu_valid),
      .lu_ready       (lu_ready),
      .lu_waddr       (lu_waddr),
      .lu_wdata       (lu_wdata),
      .lu_issue_valid (lu_issue_valid),
      .lu_issue_rd    (lu_issue_rd),
      .pend_mask      (pend_mask),
      .rf_we          (rf_we),
      .rf_waddr       (rf_waddr),
      .rf_wdata       (rf_wdata)
`ifdef RF_WB_ARB_PERF_EN
      ,
      .perf_conflicts (perf_conflicts),
      .perf_forced    (perf_forced)
`endif
   );

   int tests = 0;
   int fails = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model: arbitration from the rules, with a count of consecutive lost LU cycles.
   int            lost;
   bit            force_now;
   bit            m_we;
   logic [AW-1:0] m_addr;
   logic [RW-1:0] m_data;
   logic [RC-1:0] m_pend;
   bit            m_acc;
   bit            m_stall;
   bit            pr, lr, er, es, wl, wp;

   always @(negedge clk) begin
      if (rst) begin
         chk("rst_stall", 64'(pipe_stall), 64'd0);
         chk("rst_ready", 64'(lu_ready), 64'd0);
         chk("rst_we", 64'(rf_we), 64'd0);
         chk("rst_pend", 64'(pend_mask), 64'd0);
         chk("rst_waddr", 64'(rf_waddr), 64'd0);
         chk("rst_wdata", rf_wdata, 64'd0);
         lost = 0; force_now = 0; m_we = 0; m_addr = '0; m_data = '0;
         m_pend = '0; m_acc = 0; m_stall = 0;
      end else begin
         pr = pipe_wvalid && (pipe_waddr != 0);
         lr = lu_valid && (lu_waddr != 0);
         if (force_now) begin
            er = lu_valid;
            es = pr && lu_valid;
         end else begin
            er = lu_valid && !pr;
            es = 0;
         end
         chk("lu_ready", 64'(lu_ready), 64'(er));
         chk("pipe_stall", 64'(pipe_stall), 64'(es));
         chk("rf_we", 64'(rf_we), 64'(m_we));
         chk("rf_waddr", 64'(rf_waddr), 64'(m_addr));
         chk("rf_wdata", rf_wdata, m_data);
         chk("pend_mask", 64'(pend_mask), 64'(m_pend));
         wl = er && lr;
         wp = pr && !es && !wl;
         m_we = wl || wp;
         if (wl) begin m_addr = lu_waddr; m_data = lu_wdata; end
         else if (wp) begin m_addr = pipe_waddr; m_data = pipe_wdata; end
         if (force_now) begin
            force_now = 0;
            lost = 0;
         end else if (lu_valid && !er) begin
            lost++;
            if (lost >= int'(MW)) force_now = 1;
         end else begin
            lost = 0;
         end
         if (wl) m_pend[lu_waddr] = 1'b0;
         if (lu_issue_valid && lu_issue_rd != 0) m_pend[lu_issue_rd] = 1'b1;
         m_acc = er;
         m_stall = es;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      pipe_wvalid = 0; pipe_waddr = '0; pipe_wdata = '0;
      lu_valid = 0; lu_waddr = '0; lu_wdata = '0;
      lu_issue_valid = 0; lu_issue_rd = '0;
   endtask

   initial begin
      rst = 1'b1;
      idle();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      tick();

      // LU alone: granted at once, written one edge later.
      lu_valid = 1; lu_waddr = 5'd5; lu_wdata = 64'hAB;
      @(negedge clk); chk("s1_ready", 64'(lu_ready), 64'd1);
      tick(); idle();
      @(negedge clk);
      chk("s1_we", 64'(rf_we), 64'd1);
      chk("s1_addr", 64'(rf_waddr), 64'd5);
      chk("s1_data", rf_wdata, 64'hAB);
      tick();

      // Pipeline x3 every cycle vs LU x7: four losses, then forced grant.
      pipe_wvalid = 1; pipe_waddr = 5'd3; pipe_wdata = 64'h33;
      lu_valid = 1; lu_waddr = 5'd7; lu_wdata = 64'h77;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("s2_lost_ready", 64'(lu_ready), 64'd0);
         chk("s2_lost_stall", 64'(pipe_stall), 64'd0);
         tick();
      end
      @(negedge clk);
      chk("s2_force_ready", 64'(lu_ready), 64'd1);
      chk("s2_force_stall", 64'(pipe_stall), 64'd1);
      chk("s2_prev_addr", 64'(rf_waddr), 64'd3);
      tick();
      lu_valid = 0;
      @(negedge clk);
      chk("s2_lu_addr", 64'(rf_waddr), 64'd7);
      chk("s2_lu_data", rf_wdata, 64'h77);
      chk("s2_stall_off", 64'(pipe_stall), 64'd0);
`ifdef RF_WB_ARB_PERF_EN
      chk("perf_conflicts", 64'(perf_conflicts), 64'd4);
      chk("perf_forced", 64'(perf_forced), 64'd1);
`endif
      tick();
      @(negedge clk);
      chk("s2_resume_addr", 64'(rf_waddr), 64'd3);
      chk("s2_resume_data", rf_wdata, 64'h33);
      tick(); idle(); tick();

      // Pipe write to x0 does not block the LU.
      pipe_wvalid = 1; pipe_waddr = '0; pipe_wdata = 64'hDEAD;
      lu_valid = 1; lu_waddr = 5'd9; lu_wdata = 64'h99;
      @(negedge clk);
      chk("s3_ready", 64'(lu_ready), 64'd1);
      chk("s3_stall", 64'(pipe_stall), 64'd0);
      tick(); idle();
      @(negedge clk);
      chk("s3_addr", 64'(rf_waddr), 64'd9);
      chk("s3_data", rf_wdata, 64'h99);
      tick();
      @(negedge clk); chk("s3_no_we", 64'(rf_we), 64'd0);

      // Scoreboard set, clear, and same-cycle set-over-clear.
      lu_issue_valid = 1; lu_issue_rd = 5'd12;
      tick(); idle();
      @(negedge clk); chk("s4_set", 64'(pend_mask), 64'h1000);
      lu_valid = 1; lu_waddr = 5'd12; lu_wdata = 64'hC;
      tick(); idle();
      @(negedge clk); chk("s4_clr", 64'(pend_mask), 64'h0);
      lu_valid = 1; lu_waddr = 5'd12; lu_wdata = 64'hC;
      lu_issue_valid = 1; lu_issue_rd = 5'd12;
      tick(); idle();
      @(negedge clk); chk("s4_set_wins", 64'(pend_mask), 64'h1000);
      tick();

      // Reset hitting mid-FORCE.
      pipe_wvalid = 1; pipe_waddr = 5'd3; pipe_wdata = 64'h33;
      lu_valid = 1; lu_waddr = 5'd7; lu_wdata = 64'h77;
      repeat (4) tick();
      chk("s5_in_force", 64'(pipe_stall), 64'd1);
      rst = 1'b1; lu_valid = 0;
      #1;
      chk("s5_rst_stall", 64'(pipe_stall), 64'd0);
      chk("s5_rst_ready", 64'(lu_ready), 64'd0);
      chk("s5_rst_we", 64'(rf_we), 64'd0);
      chk("s5_rst_pend", 64'(pend_mask), 64'd0);
      tick();
      rst = 1'b0;
      lu_valid = 1; lu_waddr = 5'd7; lu_wdata = 64'h77;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); chk("s5_normal_ready", 64'(lu_ready), 64'd0);
         tick();
      end
      @(negedge clk); chk("s5_force_again", 64'(lu_ready), 64'd1);
      tick(); idle(); tick();

      // Randomized traffic respecting both handshakes.
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 199) == 0) begin
            rst = 1'b1;
            idle();
            tick();
            rst = 1'b0;
         end else begin
            if (!m_stall) begin
               pipe_wvalid = ($urandom_range(0, 3) != 0);
               pipe_waddr  = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom);
               pipe_wdata  = {$urandom, $urandom};
            end
            if (!lu_valid || m_acc) begin
               lu_valid = ($urandom_range(0, 2) == 0);
               lu_waddr = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom);
               lu_wdata = {$urandom, $urandom};
            end
            lu_issue_valid = ($urandom_range(0, 3) == 0);
            lu_issue_rd    = AW'($urandom);
            tick();
         end
      end
      idle();
      tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
Shares the single register-file write port between the in-order pipeline writeback stage and one long-latency unit (mul/div/load-miss return). The pipeline gets fixed priority, and the long-latency unit (LU) waits. Starvation of the LU is bounded: after MAX_WAIT lost cycles the pipeline is stalled for one cycle and the LU is granted. The block also keeps a pending-destination scoreboard so the hazard logic can stall readers of registers still owed by the LU.

Parameters:
REG_WIDTH, 64, data width of a register write
REG_COUNT, 32, number of architectural registers; address width is $clog2(REG_COUNT)
MAX_WAIT, 4, consecutive lost arbitration cycles before the LU is forced through (>=1)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
pipe_wvalid  in  1  pipeline WB has a write this cycle
pipe_waddr  in  AW  pipeline destination register
pipe_wdata  in  REG_WIDTH  pipeline write data
pipe_stall  out  1  freeze pipeline; WB holds its write for the next cycle
lu_valid  in  1  LU has a result to write
lu_ready  out  1  LU result accepted this cycle
lu_waddr  in  AW  LU destination register
lu_wdata  in  REG_WIDTH  LU write data
lu_issue_valid  in  1  instruction dispatched to the LU this cycle
lu_issue_rd  in  AW  destination of the dispatched LU instruction
pend_mask  out  REG_COUNT  bit r=1: register r has an outstanding LU write
rf_we  out  1  register file write enable (registered)
rf_waddr  out  AW  register file write address (registered)
rf_wdata  out  REG_WIDTH  register file write data (registered)

Behaviour:
- Definitions: pipe_real = pipe_wvalid && pipe_waddr!=0; lu_real = lu_valid && lu_waddr!=0.
- States: NORMAL and FORCE. Reset state is NORMAL.
- Grant in NORMAL:
  - pipe_real wins if asserted.
  - LU is granted (lu_ready=1) when lu_valid && !pipe_real.
  - pipe_stall=0.
- Grant in FORCE:
  - LU is granted when lu_valid.
  - pipe_stall = pipe_real, combinational from pipe_real and state.
  - The pipeline write is not performed; it repeats next cycle.
- x0 writes:
  - A pipe write to x0 is absorbed: no rf_we and no conflict, so the LU may be granted the same cycle.
  - An LU write to x0 is acknowledged (lu_ready=1) with no rf_we.
- wait_cnt (width $clog2(MAX_WAIT+1)):
  - Increments each cycle lu_valid && !lu_ready.
  - Clears when lu_ready or !lu_valid.
  - NORMAL->FORCE when the incremented value reaches MAX_WAIT.
  - FORCE->NORMAL always after one cycle. If lu_valid was low in FORCE, nothing is granted and there is no stall.
- Handshake: lu_valid, lu_waddr and lu_wdata must stay stable until lu_ready. lu_ready is combinational from inputs and state; it is never asserted without lu_valid.
- Output path: the granted write is registered. rf_we/rf_waddr/rf_wdata update on the clk edge after the grant, so latency is 1 cycle. rf_we=0 when nothing real is granted, and rf_waddr/rf_wdata hold their previous values.
- Scoreboard:
  - lu_issue_valid && lu_issue_rd!=0 sets pend[rd] next edge.
  - An accepted LU write clears pend[lu_waddr] next edge.
  - If a set and a clear hit the same register in the same cycle, the set wins.
  - pend_mask[0] is constant 0. pend_mask is registered.
- Reset (async, any time, including mid-FORCE):
  - state=NORMAL, wait_cnt=0, pend_mask=0, rf_we=0, rf_waddr=0, rf_wdata=0.
  - pipe_stall=0 and lu_ready=0 while rst is high.
  - An LU result in flight when reset hits is dropped.

Optional Feature:
RF_WB_ARB_PERF_EN:
- Defined: adds outputs perf_conflicts[31:0] and perf_forced[31:0].
  - perf_conflicts counts cycles with pipe_real && lu_valid in NORMAL.
  - perf_forced counts cycles in FORCE with pipe_stall=1.
  - Both saturate at 32'hFFFF_FFFF and reset to 0.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package rf_wb_arb_pkg: arb_state_e enum {NORMAL, FORCE}; localparam for the address-width function; perf counter width constant.
- Sub-module rf_scoreboard: holds pend_mask set/clear logic, parameterised by REG_COUNT. The instance is driven by the arbiter's LU accept signal.

Test Plan:
- Only lu_valid=1 with waddr=5, wdata=0xAB -> lu_ready=1 same cycle; next edge rf_we=1, rf_waddr=5, rf_wdata=0xAB.
- pipe_real (x3) held every cycle while lu_valid (x7) is held, MAX_WAIT=4 -> lu_ready=0 for 4 cycles; 5th cycle FORCE with pipe_stall=1 and lu_ready=1; rf writes x7, then x3 resumes the following cycle.
- pipe_wvalid with waddr=0 plus lu_valid (x9) -> lu_ready=1, no stall; only the x9 write reaches rf, and no rf_we for x0.
- lu_issue rd=12 -> pend_mask[12]=1; LU write to x12 accepted -> bit clears next edge. A same-cycle issue to 12 and accept of 12 -> bit stays 1.
- rst asserted mid-FORCE with pend_mask=0x1000 -> immediately pipe_stall=0, lu_ready=0, rf_we=0, pend_mask=0; after release, state is NORMAL and wait_cnt=0.
- With RF_WB_ARB_PERF_EN, run the second scenario -> perf_conflicts=4, perf_forced=1.
